// File: rtl/fib_arbiter.sv
// Round-robin front end that shares one Fibonacci accelerator among NREQ requesters,
// with a watchdog that turns a silent accelerator into an error response.
module fib_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned N_W   = 6,
  parameter int unsigned RES_W = 32,
  parameter int unsigned TMO   = 1024
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*N_W-1:0]  req_n,
  output logic [NREQ-1:0]      rsp_vld,
  input  logic [NREQ-1:0]      rsp_rdy,
  output logic [RES_W-1:0]     rsp_data,
  output logic                 rsp_err,
  output logic                 core_vld_in,
  input  logic                 core_rdy_in,
  output logic [N_W-1:0]       core_n,
  input  logic                 core_vld_out,
  input  logic [RES_W-1:0]     core_result,
  output logic                 core_rdy_out,
  output logic                 busy
);

  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WD_W = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id;
  logic [ID_W-1:0]   grant;
  logic              any_req;
  logic [N_W-1:0]    n;
  logic [RES_W-1:0]  result;
  logic              err;
  logic [WD_W-1:0]   wdog;
  int unsigned       rr_idx;
  logic [N_W-1:0]    req_n_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign req_n_a[i] = req_n[i*N_W +: N_W];
  end

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    rr_idx  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_idx = 32'(ptr) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (!any_req && req_vld[ID_W'(rr_idx)]) begin
        any_req = 1'b1;
        grant   = ID_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      id     <= '0;
      n      <= '0;
      result <= '0;
      err    <= 1'b0;
      wdog   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            id    <= grant;
            n     <= req_n_a[grant];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (core_rdy_in) begin
            wdog  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // A result arriving on the final watchdog cycle still wins.
          if (core_vld_out) begin
            result <= core_result;
            err    <= 1'b0;
            state  <= RESP;
          end else if (wdog == WD_W'(TMO - 1)) begin
            result <= '0;
            err    <= 1'b1;
            state  <= RESP;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        RESP: begin
          if (rsp_rdy[id]) begin
            ptr   <= (id == ID_W'(NREQ - 1)) ? '0 : id + ID_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state; only req_rdy also looks at live inputs.
  always_comb begin
    req_rdy      = '0;
    rsp_vld      = '0;
    rsp_data     = '0;
    rsp_err      = 1'b0;
    core_vld_in  = 1'b0;
    core_n       = '0;
    core_rdy_out = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:  if (any_req) req_rdy = NREQ'(1) << grant;
      ISSUE: begin
        core_vld_in = 1'b1;
        core_n      = n;
      end
      WAIT:  core_rdy_out = 1'b1;
      RESP: begin
        rsp_vld  = NREQ'(1) << id;
        rsp_data = result;
        rsp_err  = err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fib_arbiter.sv
// Bench for fib_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_fib_arbiter;
  localparam int NREQ = 4;
  localparam int N_W  = 6;
  localparam int RES_W = 32;
  localparam int TMO  = 16;

  logic                CLK = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_vld = '0;
  logic [NREQ-1:0]     req_rdy;
  logic [NREQ*N_W-1:0] req_n = '0;
  logic [NREQ-1:0]     rsp_vld;
  logic [NREQ-1:0]     rsp_rdy = '0;
  logic [RES_W-1:0]    rsp_data;
  logic                rsp_err;
  logic                core_vld_in;
  logic                core_rdy_in = 1'b0;
  logic [N_W-1:0]      core_n;
  logic                core_vld_out = 1'b0;
  logic [RES_W-1:0]    core_result = '0;
  logic                core_rdy_out;
  logic                busy;

  fib_arbiter #(.NREQ(NREQ), .N_W(N_W), .RES_W(RES_W), .TMO(TMO)) dut (
    .CLK(CLK), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_n(req_n),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_vld_in(core_vld_in), .core_rdy_in(core_rdy_in), .core_n(core_n),
    .core_vld_out(core_vld_out), .core_result(core_result),
    .core_rdy_out(core_rdy_out), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          id;
    int          n;
    logic [31:0] data;
    bit          err;
    int          acc;
    int          first;
    int          hs;
  } txn_t;

  txn_t rlog[$];
  int   glog[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fib(input int k);
    logic [31:0] a, b, t;
    a = 32'd0;
    b = 32'd1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int rr_grant(input int p, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Accelerator and response-side environment, controlled by these knobs.
  int rdy_dly = 0, vld_dly = 0, rsp_dly = 0;
  bit core_never = 0, rnd_mode = 0;
  int issue_cnt = 0, wait_cnt = 0, resp_cnt = 0;
  logic [N_W-1:0] pend_n = '0;

  always @(posedge CLK) begin
    #1;
    if (core_vld_in) begin
      if (issue_cnt == 0) pend_n = core_n;
      core_rdy_in = (rdy_dly < 0) ? 1'($urandom_range(1, 0)) : (issue_cnt >= rdy_dly);
      issue_cnt++;
    end else begin
      issue_cnt = 0;
      core_rdy_in = rnd_mode ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    if (core_rdy_out) begin
      core_vld_out = !core_never && ((vld_dly < 0) ? 1'($urandom_range(1, 0)) : (wait_cnt >= vld_dly));
      core_result = fib(int'(pend_n));
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      core_vld_out = rnd_mode ? 1'($urandom_range(1, 0)) : 1'b0;
      core_result = $urandom;
    end
    if (|rsp_vld) begin
      if ((rsp_dly < 0) ? 1'($urandom_range(1, 0)) : (resp_cnt >= rsp_dly))
        rsp_rdy = rsp_vld | NREQ'($urandom);
      else
        rsp_rdy = NREQ'($urandom) & ~rsp_vld;
      resp_cnt++;
    end else begin
      resp_cnt = 0;
      rsp_rdy = rnd_mode ? NREQ'($urandom) : '0;
    end
  end

  // Transaction-level model: phase 0 idle, 1 issuing, 2 waiting on core, 3 responding.
  int          m_ph = 0, m_ptr = 0, m_id = 0, m_wc = 0;
  logic [N_W-1:0] m_n = '0;
  logic [31:0] m_res = '0;
  bit          m_err = 0, m_valid = 0;
  txn_t        cur;

  always @(negedge CLK) begin : model
    int g;
    logic [NREQ-1:0] e_rdy, e_rsp;
    g = rr_grant(m_ptr, req_vld);
    if (m_valid) begin
      e_rdy = (m_ph == 0 && g >= 0) ? NREQ'(1 << g) : '0;
      e_rsp = (m_ph == 3) ? NREQ'(1 << m_id) : '0;
      chk("req_rdy", req_rdy, e_rdy);
      chk("busy", busy, m_ph != 0);
      chk("core_vld_in", core_vld_in, m_ph == 1);
      chk("core_n", core_n, (m_ph == 1) ? m_n : '0);
      chk("core_rdy_out", core_rdy_out, m_ph == 2);
      chk("rsp_vld", rsp_vld, e_rsp);
      chk("rsp_data", rsp_data, (m_ph == 3) ? m_res : 32'd0);
      chk("rsp_err", rsp_err, m_ph == 3 && m_err);
    end
    if (rst) begin
      m_ph = 0; m_ptr = 0; m_id = 0; m_n = '0; m_res = '0; m_err = 0; m_wc = 0;
      m_valid = 1;
    end else if (m_valid) begin
      case (m_ph)
        0: if (g >= 0) begin
          m_id = g;
          m_n = req_n[g*N_W +: N_W];
          m_ph = 1;
          glog.push_back(g);
          cur.id = g; cur.n = int'(m_n); cur.acc = cyc;
        end
        1: if (core_rdy_in) begin
          m_ph = 2;
          m_wc = 0;
        end
        2: if (core_vld_out) begin
          m_res = core_result; m_err = 0; m_ph = 3; cur.first = cyc + 1;
        end else if (m_wc == TMO - 1) begin
          m_res = '0; m_err = 1; m_ph = 3; cur.first = cyc + 1;
        end else begin
          m_wc++;
        end
        default: if (rsp_rdy[m_id]) begin
          m_ptr = (m_id + 1) % NREQ;
          m_ph = 0;
          cur.data = m_res; cur.err = m_err; cur.hs = cyc;
          rlog.push_back(cur);
        end
      endcase
    end
  end

  task automatic set_n(input int i, input int v);
    req_n[i*N_W +: N_W] = N_W'(v);
  endtask

  task automatic send(input logic [NREQ-1:0] mask);
    int start;
    bit ok;
    start = glog.size();
    ok = 0;
    @(posedge CLK); #1;
    req_vld = mask;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge CLK); #1;
      if (glog.size() > start) ok = 1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL grant_timeout actual=none required=grant");
    end
    @(posedge CLK); #1;
    req_vld = '0;
  endtask

  task automatic wait_rsp(input int target);
    bit ok;
    ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge CLK); #1;
      if (rlog.size() >= target) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_timeout actual=%0d required=%0d responses", rlog.size(), target);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge CLK); #1;
      if (m_ph == 0 && !busy) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic check_rsp(input string tag, input int idx, input int id, input longint data,
                           input bit err, input int lat);
    if (rlog.size() > idx) begin
      chk({tag, "_id"}, rlog[idx].id, id);
      chk({tag, "_data"}, rlog[idx].data, data);
      chk({tag, "_err"}, rlog[idx].err, err);
      if (lat >= 0) chk({tag, "_latency"}, rlog[idx].first - rlog[idx].acc, lat);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    rst = 1'b1;
    @(posedge CLK); #1;
    rst = 1'b0;
  endtask

  initial begin : main
    int rs, ga;
    int exp_g[5];
    int exp_d[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{1, 1, 2, 3, 1};

    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
    @(negedge CLK); #1;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_rsp_vld", rsp_vld, 0);
    chk("post_reset_core_vld_in", core_vld_in, 0);
    chk("post_reset_rsp_data", rsp_data, 0);

    // Single request
    set_n(2, 10);
    rs = rlog.size(); ga = glog.size();
    send(4'b0100);
    wait_rsp(rs + 1);
    if (glog.size() > ga) chk("single_grant", glog[ga], 2);
    check_rsp("single", rs, 2, 55, 0, 3);
    wait_idle();

    // Fairness and back-to-back spacing from ptr=0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_n(i, i + 1);
    rs = rlog.size(); ga = glog.size();
    @(posedge CLK); #1;
    req_vld = 4'b1111;
    for (int k = 0; k < 200 && glog.size() < ga + 5; k++) begin
      @(negedge CLK); #1;
    end
    @(posedge CLK); #1;
    req_vld = '0;
    wait_rsp(rs + 5);
    for (int k = 0; k < 5; k++) begin
      if (glog.size() > ga + k) chk("fair_grant", glog[ga + k], exp_g[k]);
      check_rsp("fair", rs + k, exp_g[k], exp_d[k], 0, 3);
    end
    if (rlog.size() > rs + 1) chk("fair_spacing", rlog[rs + 1].acc - rlog[rs].acc, 4);
    wait_idle();

    // Backpressure on both core start and response
    rdy_dly = 5; rsp_dly = 4;
    set_n(1, 20);
    rs = rlog.size();
    send(4'b0010);
    wait_rsp(rs + 1);
    wait_idle();
    check_rsp("bp", rs, 1, 6765, 0, 8);
    if (rlog.size() > rs) chk("bp_resp_hold", rlog[rs].hs - rlog[rs].first, 4);
    chk("bp_count", rlog.size() - rs, 1);
    rdy_dly = 0; rsp_dly = 0;

    // Watchdog timeout, then a result on the last watchdog cycle
    core_never = 1;
    set_n(3, 5);
    rs = rlog.size();
    send(4'b1000);
    wait_rsp(rs + 1);
    wait_idle();
    check_rsp("tmo", rs, 3, 0, 1, 18);
    core_never = 0; vld_dly = TMO - 1;
    set_n(0, 7);
    send(4'b0001);
    wait_rsp(rs + 2);
    wait_idle();
    check_rsp("tmo_edge", rs + 1, 0, 13, 0, 18);
    vld_dly = 0;

    // Pointer wrap after grant 3
    ga = glog.size();
    set_n(3, 2);
    send(4'b1000);
    wait_idle();
    send(4'b1001);
    wait_idle();
    if (glog.size() > ga + 1) begin
      chk("wrap_first", glog[ga], 3);
      chk("wrap_next", glog[ga + 1], 0);
    end

    // Reset in WAIT abandons the transaction and restarts the pointer
    send(4'b0010);
    wait_idle();
    core_never = 1;
    set_n(2, 9);
    send(4'b0100);
    for (int k = 0; k < 50 && !core_rdy_out; k++) begin
      @(negedge CLK); #1;
    end
    chk("mid_wait_reached", core_rdy_out, 1);
    rs = rlog.size();
    do_reset();
    @(negedge CLK); #1;
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_rsp_vld", rsp_vld, 0);
    chk("rst_wait_core_rdy_out", core_rdy_out, 0);
    chk("rst_wait_no_rsp", rlog.size(), rs);
    core_never = 0;
    ga = glog.size();
    send(4'b0101);
    wait_idle();
    if (glog.size() > ga) chk("rst_ptr_grant", glog[ga], 0);

    // Random traffic
    rnd_mode = 1; rdy_dly = -1; vld_dly = -1; rsp_dly = -1;
    rs = rlog.size();
    for (int k = 0; k < 3000; k++) begin
      @(posedge CLK); #1;
      req_vld = NREQ'($urandom);
      req_n = ($urandom_range(3, 0) == 0) ? '0 : (NREQ*N_W)'($urandom);
      rst = ($urandom_range(199, 0) == 0);
    end
    @(posedge CLK); #1;
    rst = 1'b0; req_vld = '0;
    rnd_mode = 0; rdy_dly = 0; vld_dly = 0; rsp_dly = 0;
    wait_idle();
    for (int k = rs; k < rlog.size(); k++)
      if (!rlog[k].err) chk("rnd_fib", rlog[k].data, fib(rlog[k].n));
    chk("rnd_saw_responses", rlog.size() > rs + 50, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/fib_arbiter.md
FIB_ARBITER -- requirements
Module: fib_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NREQ, 4, number of requesters (2..8).
REQ-002 N_W, 6, width of the Fibonacci index.
REQ-003 RES_W, 32, result width.
REQ-004 TMO, 1024, watchdog limit in cycles for the WAIT state.
REQ-005 Ports SHALL be (name, direction, width, meaning): CLK, in, 1, sole clock (rising edge).
REQ-006 rst, in, 1, synchronous active-high reset.
REQ-007 req_vld, in, NREQ, per-requester request valid.
REQ-008 req_rdy, out, NREQ, per-requester request accept (one-hot or zero).
REQ-009 req_n, in, NREQ*N_W, per-requester index; slice i is [i*N_W +: N_W].
REQ-010 rsp_vld, out, NREQ, per-requester response valid (one-hot or zero).
REQ-011 rsp_rdy, in, NREQ, per-requester response accept.
REQ-012 rsp_data, out, RES_W, shared response payload.
REQ-013 rsp_err, out, 1, response is a watchdog timeout.
REQ-014 core_vld_in, out, 1, start request to the accelerator.
REQ-015 core_rdy_in, in, 1, accelerator accepts start.
REQ-016 core_n, out, N_W, index sent to the accelerator.
REQ-017 core_vld_out, in, 1, accelerator result valid.
REQ-018 core_result, in, RES_W, accelerator result.
REQ-019 core_rdy_out, out, 1, arbiter ready for the result.
REQ-020 busy, out, 1, high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-022 Any other encoding SHALL return to IDLE on the next edge.
REQ-023 Round-robin pointer ptr: in IDLE, grant g is the first i with req_vld[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
REQ-024 In IDLE, req_rdy[g]=1 combinationally in the same cycle; the handshake completes that cycle.
REQ-025 On that handshake, the arbiter SHALL latch id<=g and n<=req_n slice g, then go to ISSUE.
REQ-026 If no req_vld bit is set, the FSM SHALL stay in IDLE with req_rdy=0.
REQ-027 ISSUE: core_vld_in=1 and core_n=latched n, both held stable until core_rdy_in=1, then go to WAIT.
REQ-028 WAIT: core_rdy_out=1.
REQ-029 On core_vld_out=1 in WAIT, the arbiter SHALL capture core_result, set err<=0 and go to RESP.
REQ-030 A watchdog counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-031 If the watchdog counter reaches TMO-1 without core_vld_out, the arbiter SHALL set result<=0 and err<=1 and go to RESP.
REQ-032 If core_vld_out=1 in that same cycle, the valid result SHALL win (err=0).
REQ-033 RESP: rsp_vld[id]=1, rsp_data=result and rsp_err=err, held stable until rsp_rdy[id]=1.
REQ-034 When rsp_rdy[id]=1 in RESP, the arbiter SHALL set ptr<=(id+1) mod NREQ and go to IDLE.
REQ-035 rsp_rdy bits other than rsp_rdy[id] SHALL be ignored.
REQ-036 Only one transaction SHALL be outstanding at a time; req_rdy=0 in ISSUE, WAIT and RESP.
REQ-037 A requester holding req_vld high SHALL NOT be starved: its worst-case wait is NREQ-1 transactions.
REQ-038 Minimum latency: accept at cycle 0, core_vld_in at 1; with core_rdy_in=1 at 1 and core_vld_out=1 at 2, rsp_vld is at 3.
REQ-039 Minimum throughput: back-to-back transactions start 4 cycles apart.
REQ-040 Outputs not driven by the current state SHALL be 0; rsp_data and rsp_err SHALL be 0 outside RESP.

Reset
REQ-041 On a CLK edge with rst=1, the arbiter SHALL set FSM=IDLE, ptr=0, id=0, n=0, result=0, err=0 and watchdog=0.
REQ-042 Reset SHALL take precedence over every transition.
REQ-043 Reset asserted mid-transaction (ISSUE, WAIT or RESP) SHALL abandon that transaction with no response.
REQ-044 In the cycle after reset deasserts, all outputs SHALL be 0.

Verification
REQ-045 Single request: req_vld[2]=1 with n=10, core model returns fib -> rsp_vld[2]=1, rsp_data=55, rsp_err=0, 3 cycles after accept.
REQ-046 Fairness: all 4 req_vld held high with n=i+1 -> grants in order 0,1,2,3,0; responses 1,1,2,3.
REQ-047 Backpressure: core_rdy_in low 5 cycles and rsp_rdy low 4 cycles -> core_vld_in, core_n, rsp_vld and rsp_data stable throughout; exactly one response.
REQ-048 Timeout: TMO=16, core never asserts core_vld_out -> RESP after 16 WAIT cycles with rsp_err=1 and rsp_data=0; same-cycle core_vld_out at count 15 -> err=0.
REQ-049 Reset mid-WAIT -> next cycle FSM=IDLE, all outputs 0, no rsp_vld; a new request afterwards is granted starting from ptr=0.
REQ-050 Pointer wrap: last grant id=3 (NREQ=4), then req_vld=4'b1001 -> grant 0 next.
